spi_tx_framer: RTL
==================

Name: spi_tx_framer

Overview:
- Produces the MISO byte stream for the SPI target's transmit side (drives its i_tx_data; consumes its o_tx_data_hold).
- Replaces raw PC-byte debug with framed 32-bit readback: header, 4 data bytes big-endian, XOR checksum, then idle fill.
- Snapshots the selected source word at frame start, so the host always reads a coherent 32-bit value while the CPU runs.

Parameters:
- HEADER, 8'hA5, first byte of every frame.
- IDLE_BYTE, 8'hFF, byte driven outside a frame and after the checksum.
- ID_WORD, 32'h5348_5256, constant returned for source select 3.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_ss_n  in  1  SPI chip select, raw pin, asynchronous to clk
- i_tx_hold  in  1  single-cycle pulse from SPI target: current o_tx_data has been latched for shifting
- i_src_sel  in  2  source select: 0 PC, 1 DMEM read data, 2 status, 3 ID_WORD
- i_pc  in  32  CPU debug PC
- i_dmem_rdata  in  32  DMEM readback data
- i_status  in  32  status word
- o_tx_data  out  8  byte presented to the SPI target, registered
- o_frame_active  out  1  high from frame start until ss_n deassert
- o_frame_done  out  1  one-cycle pulse when the checksum byte is consumed
- o_frame_count  out  8  completed-frame counter, wraps 255->0

Behaviour:
- Reset (async, rst_n low):
  - o_tx_data = IDLE_BYTE; o_frame_active = 0; o_frame_done = 0; o_frame_count = 0.
  - State IDLE; snapshot = 0; ss_n synchroniser flops s1/s2/s3 = 1.
- ss_n synchroniser: s1 <= i_ss_n, s2 <= s1, s3 <= s2.
  - fall = s3 & ~s2; rise = ~s3 & s2.
  - Frame start takes effect on the 3rd rising clk edge after i_ss_n falls; o_tx_data = HEADER is visible from that edge.
- States: IDLE, HDR, B3, B2, B1, B0, CSUM, TAIL.
- On fall, from any state:
  - snapshot <= word selected by i_src_sel (sampled only here).
  - State HDR; o_tx_data <= HEADER; o_frame_active <= 1.
- Advancing on i_tx_hold; o_tx_data is updated on the same edge as the state:
  - HDR->B3 (snapshot[31:24]); B3->B2 ([23:16]); B2->B1 ([15:8]); B1->B0 ([7:0]).
  - B0->CSUM (o_tx_data = snapshot[31:24]^[23:16]^[15:8]^[7:0]).
  - CSUM->TAIL (IDLE_BYTE), with o_frame_done = 1 for exactly one cycle and o_frame_count += 1.
- TAIL: o_tx_data = IDLE_BYTE; i_tx_hold ignored until rise or a new fall.
- Latency: the next byte is valid 1 clk after the i_tx_hold pulse; holds arrive at least 8 clk apart.
- On rise, from any state: IDLE; o_tx_data <= IDLE_BYTE; o_frame_active <= 0.
  - Aborted frame (rise before CSUM consumed): no frame_done, count unchanged.
- Simultaneous events:
  - fall and i_tx_hold in the same cycle: fall wins, hold dropped.
  - rise and i_tx_hold in the same cycle: rise wins; no done pulse even if the state was CSUM.
- i_tx_hold in IDLE is ignored and o_tx_data stays IDLE_BYTE.
- Source inputs changing mid-frame have no effect on the bytes sent.
- Reset mid-frame returns all outputs to reset values immediately (asynchronous).

Test Plan:
- Reset: hold rst_n low, toggle i_ss_n and i_tx_hold -> o_tx_data=8'hFF, active=0, count=0 throughout.
- PC frame: i_src_sel=0, i_pc=32'h0000_1234, drop ss_n, 6 hold pulses spaced 8 clk:
  - o_tx_data sequence A5,00,00,12,34,26, then FF.
  - One o_frame_done pulse; count=1.
  - A 7th hold keeps FF.
- ID frame: i_src_sel=3 -> A5,53,48,52,56,1F; count increments.
- Snapshot coherence: i_src_sel=0, i_pc=32'hDEAD_BEEF at fall; change i_pc to 32'h0 after the HDR hold -> bytes A5,DE,AD,BE,EF,22.
- Abort: raise ss_n after 3 holds -> IDLE, o_tx_data=FF, no done pulse, count unchanged. A new fall restarts with A5 and a fresh snapshot.
- Boundary:
  - fall coincident with hold -> HEADER presented, hold not counted.
  - 256 complete frames -> o_frame_count wraps to 0.
  - rst_n low during B1 -> outputs at reset values on the same cycle.

Source files
------------

// File: rtl/spi_tx_framer_if.sv
// Bundles the framer's SPI-target, CPU-source and frame-status signals.
// No latency or flow control of its own; the slave modport is the framer side.
// The master side drives selection, sources and hold pulses, and observes the framer outputs.
interface spi_tx_framer_if;
    logic        i_ss_n;
    logic        i_tx_hold;
    logic [1:0]  i_src_sel;
    logic [31:0] i_pc;
    logic [31:0] i_dmem_rdata;
    logic [31:0] i_status;
    logic [7:0]  o_tx_data;
    logic        o_frame_active;
    logic        o_frame_done;
    logic [7:0]  o_frame_count;

    modport master (
        output i_ss_n, i_tx_hold, i_src_sel, i_pc, i_dmem_rdata, i_status,
        input  o_tx_data, o_frame_active, o_frame_done, o_frame_count
    );

    modport slave (
        input  i_ss_n, i_tx_hold, i_src_sel, i_pc, i_dmem_rdata, i_status,
        output o_tx_data, o_frame_active, o_frame_done, o_frame_count
    );
endinterface

// File: rtl/spi_tx_framer.sv
// Frames a snapshotted 32-bit word as header, 4 bytes big-endian, XOR checksum, then idle fill.
// Latency: header 3 clk after ss_n falls; each following byte 1 clk after the tx_hold pulse.
// Backpressure: none; the SPI target paces the frame through tx_hold, and ss_n rise aborts it.
module spi_tx_framer #(
    parameter logic [7:0]  HEADER    = 8'hA5,
    parameter logic [7:0]  IDLE_BYTE = 8'hFF,
    parameter logic [31:0] ID_WORD   = 32'h5348_5256
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_tx_framer_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, HDR, B3, B2, B1, B0, CSUM, TAIL} state_t;

    state_t      state;
    logic [31:0] snapshot;
    logic        s1, s2, s3;
    logic [7:0]  tx_data;
    logic        frame_active;
    logic        frame_done;
    logic [7:0]  frame_count;
    logic [31:0] sel_word;
    logic [7:0]  csum;
    logic        fall, rise;

    // s1 is the metastability stage; edges are detected between s2 and s3 only.
    assign fall = s3 & ~s2;
    assign rise = ~s3 & s2;
    assign csum = snapshot[31:24] ^ snapshot[23:16] ^ snapshot[15:8] ^ snapshot[7:0];

    always_comb begin
        sel_word = ID_WORD;
        case (bus.i_src_sel)
            2'd0:    sel_word = bus.i_pc;
            2'd1:    sel_word = bus.i_dmem_rdata;
            2'd2:    sel_word = bus.i_status;
            default: sel_word = ID_WORD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            snapshot     <= 32'h0;
            s1           <= 1'b1;
            s2           <= 1'b1;
            s3           <= 1'b1;
            tx_data      <= IDLE_BYTE;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
            frame_count  <= 8'h0;
        end else begin
            s1         <= bus.i_ss_n;
            s2         <= s1;
            s3         <= s2;
            frame_done <= 1'b0;
            if (fall) begin
                // Frame boundaries outrank any hold arriving in the same cycle.
                snapshot     <= sel_word;
                state        <= HDR;
                tx_data      <= HEADER;
                frame_active <= 1'b1;
            end else if (rise) begin
                state        <= IDLE;
                tx_data      <= IDLE_BYTE;
                frame_active <= 1'b0;
            end else if (bus.i_tx_hold) begin
                case (state)
                    HDR: begin state <= B3; tx_data <= snapshot[31:24]; end
                    B3:  begin state <= B2; tx_data <= snapshot[23:16]; end
                    B2:  begin state <= B1; tx_data <= snapshot[15:8];  end
                    B1:  begin state <= B0; tx_data <= snapshot[7:0];   end
                    B0:  begin state <= CSUM; tx_data <= csum;          end
                    CSUM: begin
                        state       <= TAIL;
                        tx_data     <= IDLE_BYTE;
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.o_tx_data      = tx_data;
    assign bus.o_frame_active = frame_active;
    assign bus.o_frame_done   = frame_done;
    assign bus.o_frame_count  = frame_count;
endmodule
